// File: rtl/im_sync.sv
// Synchronous instruction memory for the multicycle MIPS datapath: request/valid
// fetch handshake with configurable read latency, base-address decode and a load port.
module im_sync #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [31:0]           addr,
  output logic                  busy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  fault,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("im_sync: LATENCY must be in 1..4");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("im_sync: BASE_ADDR must be 4-byte aligned");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   pend_data_q;
  logic                    pend_fault_q;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    fault_q;

  // NOTE: the program array carries no reset; clearing it would force it out of
  // block RAM into flops, and a boot loader refills it through the load port anyway.
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [31:0]             offset;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    fetch_fault;
  logic [DATA_WIDTH-1:0]   fetch_data;
  logic                    accept;
  logic                    enter_done;

  // An address below BASE_ADDR wraps to a huge offset and lands in the out-of-range test.
  assign offset      = addr - BASE_ADDR;
  assign idx         = offset[ADDR_WIDTH+1:2];
  assign fetch_fault = (addr[1:0] != 2'b00) || (|(offset >> (ADDR_WIDTH + 2)));
  assign fetch_data  = fetch_fault ? '0 : mem_q[idx];

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(LATENCY - 1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // DONE is only ever re-entered through a fresh acceptance, so this marks every completion.
  assign enter_done = (state_d == S_DONE);

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, which also gives read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      pend_data_q  <= '0;
      pend_fault_q <= 1'b0;
      dout_q       <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        pend_data_q  <= fetch_data;
        pend_fault_q <= fetch_fault;
      end
      if (enter_done) begin
        dout_q  <= (LATENCY == 1) ? fetch_data  : pend_data_q;
        fault_q <= (LATENCY == 1) ? fetch_fault : pend_fault_q;
      end
    end
  end

  // The load port ignores rst and the fetch FSM entirely.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign busy  = (state_q == S_WAIT);
  assign valid = (state_q == S_DONE);
  assign fault = valid & fault_q;
  assign dout  = dout_q;

endmodule

// File: tb/tb_im_sync.sv
// Bench for im_sync: four instances (LATENCY 1..4) driven by directed vectors,
// hand-written corner sequences and random traffic against a cycle-numbered model.
module tb_im_sync;

  localparam int          N     = 4;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [N];
  logic          req   [N];
  logic [31:0]   addr  [N];
  logic          we    [N];
  logic [AW-1:0] waddr [N];
  logic [31:0]   wdata [N];
  logic          busy  [N];
  logic          valid [N];
  logic          fault [N];
  logic [31:0]   dout  [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    im_sync #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(32),
      .LATENCY   (g + 1),
      .BASE_ADDR (BASE)
    ) u_dut (
      .clk  (clk),
      .rst  (rst[g]),
      .req  (req[g]),
      .addr (addr[g]),
      .busy (busy[g]),
      .valid(valid[g]),
      .dout (dout[g]),
      .fault(fault[g]),
      .we   (we[g]),
      .waddr(waddr[g]),
      .wdata(wdata[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: each fetch is a record of the edge number whose following
  // cycle shows valid; busy and acceptance follow from comparing edge numbers.
  logic [31:0] m_mem [N][DEPTH];
  bit          m_pend   [N];
  longint      m_v      [N];
  logic [31:0] m_pdata  [N];
  bit          m_pfault [N];
  logic [31:0] m_dout   [N];
  longint      edge_n = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_dout;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_update();
    edge_n++;
    for (int i = 0; i < N; i++) begin
      logic [31:0] off;
      bit          f;
      off = addr[i] - BASE;
      f   = (addr[i][1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
      if (!rst[i] && req[i] && (!m_pend[i] || m_v[i] < edge_n)) begin
        m_pend[i]   = 1'b1;
        m_v[i]      = edge_n + i;
        m_pfault[i] = f;
        m_pdata[i]  = f ? 32'h0 : m_mem[i][off[AW+1:2]];
      end
      if (we[i]) m_mem[i][waddr[i]] = wdata[i];
      if (rst[i]) begin
        m_pend[i] = 1'b0;
        m_dout[i] = 32'h0;
      end else if (m_pend[i] && m_v[i] == edge_n) begin
        m_dout[i] = m_pdata[i];
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      bit ev, eb;
      ev = m_pend[i] && (m_v[i] == edge_n);
      eb = m_pend[i] && (m_v[i] > edge_n);
      check($sformatf("L%0d.valid@%0d", i + 1, edge_n), 32'(valid[i]), 32'(ev));
      check($sformatf("L%0d.busy@%0d", i + 1, edge_n), 32'(busy[i]), 32'(eb));
      check($sformatf("L%0d.fault@%0d", i + 1, edge_n), 32'(fault[i]), 32'(ev && m_pfault[i]));
      check($sformatf("L%0d.dout@%0d", i + 1, edge_n), dout[i], m_dout[i]);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0;
      req[i] = 1'b0;
      we[i]  = 1'b0;
    end
  endtask

  task automatic load_all(input int k, input logic [31:0] d);
    for (int i = 0; i < N; i++) begin
      we[i]    = 1'b1;
      waddr[i] = AW'(k);
      wdata[i] = d;
    end
    cyc();
    for (int i = 0; i < N; i++) we[i] = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{32'h0000_3000, 32'h3402_1234, 1'b0};
    vecs[1]  = '{32'h0000_3004, 32'h3c03_9876, 1'b0};
    vecs[2]  = '{32'h0000_3008, 32'h2044_3456, 1'b0};
    vecs[3]  = '{32'h0000_3014, 32'h0000_abcd, 1'b0};
    vecs[4]  = '{32'h0000_3010, 32'hA500_0004, 1'b0};
    vecs[5]  = '{32'h0000_3FFC, 32'hA500_03FF, 1'b0};
    vecs[6]  = '{32'h0000_3002, 32'h0000_0000, 1'b1};
    vecs[7]  = '{32'h0000_3001, 32'h0000_0000, 1'b1};
    vecs[8]  = '{32'h0000_2FFC, 32'h0000_0000, 1'b1};
    vecs[9]  = '{32'h0000_4000, 32'h0000_0000, 1'b1};
    vecs[10] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[11] = '{32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[12] = '{32'h0000_4003, 32'h0000_0000, 1'b1};

    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; addr[i] = 32'h0;
      we[i] = 1'b0; waddr[i] = '0; wdata[i] = 32'h0;
      m_pend[i] = 1'b0; m_v[i] = 0; m_pdata[i] = 32'h0; m_pfault[i] = 1'b0; m_dout[i] = 32'h0;
      for (int k = 0; k < DEPTH; k++) m_mem[i][k] = 32'h0;
    end

    // Reset state.
    cyc();
    cyc();
    for (int i = 0; i < N; i++) begin
      check($sformatf("L%0d.reset_valid", i + 1), 32'(valid[i]), 32'h0);
      check($sformatf("L%0d.reset_dout", i + 1), dout[i], 32'h0);
    end
    idle_all();

    // Program image: distinct pattern everywhere, then the test-plan words.
    for (int k = 0; k < DEPTH; k++) load_all(k, 32'hA500_0000 | 32'(k));
    load_all(0, 32'h3402_1234);
    load_all(1, 32'h3c03_9876);
    load_all(2, 32'h2044_3456);
    load_all(5, 32'h0000_abcd);

    // Directed address-decode vectors on the single-cycle instance.
    for (int v = 0; v < 13; v++) begin
      req[0]  = 1'b1;
      addr[0] = vecs[v].addr;
      cyc();
      check($sformatf("vec%0d.valid", v), 32'(valid[0]), 32'h1);
      check($sformatf("vec%0d.dout", v), dout[0], vecs[v].exp_dout);
      check($sformatf("vec%0d.fault", v), 32'(fault[0]), 32'(vecs[v].exp_fault));
      req[0] = 1'b0;
      cyc();
      check($sformatf("vec%0d.fault_drop", v), 32'(fault[0]), 32'h0);
    end

    // LATENCY=1 back-to-back: two consecutive valids, busy never set.
    req[0] = 1'b1; addr[0] = 32'h3000;
    cyc();
    check("b2b.first", dout[0], 32'h3402_1234);
    check("b2b.busy0", 32'(busy[0]), 32'h0);
    addr[0] = 32'h3004;
    cyc();
    check("b2b.second_valid", 32'(valid[0]), 32'h1);
    check("b2b.second", dout[0], 32'h3c03_9876);
    check("b2b.busy1", 32'(busy[0]), 32'h0);
    req[0] = 1'b0;
    cyc();

    // LATENCY=3: busy in cycles 1-2, valid in cycle 3, dropped req in cycle 1.
    req[2] = 1'b1; addr[2] = 32'h3008;
    cyc();
    check("l3.c1_busy", 32'(busy[2]), 32'h1);
    addr[2] = 32'h3000;
    cyc();
    req[2] = 1'b0;
    check("l3.c2_busy", 32'(busy[2]), 32'h1);
    check("l3.c2_valid", 32'(valid[2]), 32'h0);
    cyc();
    check("l3.c3_valid", 32'(valid[2]), 32'h1);
    check("l3.c3_dout", dout[2], 32'h2044_3456);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check($sformatf("l3.no_second_valid%0d", k), 32'(valid[2]), 32'h0);
    end

    // LATENCY=2: faulted fetch leaves dout alone until its valid edge.
    req[1] = 1'b1; addr[1] = 32'h3000;
    cyc();
    req[1] = 1'b0;
    cyc();
    check("l2.good", dout[1], 32'h3402_1234);
    req[1] = 1'b1; addr[1] = 32'h3002;
    cyc();
    req[1] = 1'b0;
    check("l2.hold_dout", dout[1], 32'h3402_1234);
    cyc();
    check("l2.fault", 32'(fault[1]), 32'h1);
    check("l2.fault_dout", dout[1], 32'h0);

    // Same-cycle collision on LATENCY=1: old word, then new word.
    we[0] = 1'b1; waddr[0] = AW'(5); wdata[0] = 32'hFFFF_FFFF;
    req[0] = 1'b1; addr[0] = 32'h3014;
    cyc();
    we[0] = 1'b0;
    check("coll.old", dout[0], 32'h0000_abcd);
    cyc();
    req[0] = 1'b0;
    check("coll.new", dout[0], 32'hFFFF_FFFF);
    cyc();

    // LATENCY=2: reset the cycle after acceptance discards the fetch.
    req[1] = 1'b1; addr[1] = 32'h3004;
    cyc();
    req[1] = 1'b0; rst[1] = 1'b1;
    cyc();
    rst[1] = 1'b0;
    check("rst.valid", 32'(valid[1]), 32'h0);
    check("rst.busy", 32'(busy[1]), 32'h0);
    check("rst.dout", dout[1], 32'h0);
    cyc();
    check("rst.no_late_valid", 32'(valid[1]), 32'h0);
    req[1] = 1'b1; addr[1] = 32'h3004;
    cyc();
    req[1] = 1'b0;
    cyc();
    check("rst.after_valid", 32'(valid[1]), 32'h1);
    check("rst.after_dout", dout[1], 32'h3c03_9876);

    // LATENCY=4: write to the in-flight word during busy.
    req[3] = 1'b1; addr[3] = 32'h3018;
    cyc();
    req[3] = 1'b0;
    we[3] = 1'b1; waddr[3] = AW'(6); wdata[3] = 32'hDEAD_BEEF;
    cyc();
    we[3] = 1'b0;
    cyc();
    check("l4.busy3", 32'(busy[3]), 32'h1);
    cyc();
    check("l4.inflight_old", dout[3], 32'hA500_0006);
    req[3] = 1'b1;
    cyc();
    req[3] = 1'b0;
    cyc();
    cyc();
    cyc();
    check("l4.refetch_valid", 32'(valid[3]), 32'h1);
    check("l4.refetch_new", dout[3], 32'hDEAD_BEEF);

    // Random traffic on all instances against the model.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        rst[i] = ($urandom_range(63) == 0);
        req[i] = 1'($urandom_range(1));
        case ($urandom_range(7))
          0: addr[i] = BASE + 32'($urandom_range(15)) * 4 + 32'($urandom_range(1, 3));
          1: addr[i] = BASE - 32'($urandom_range(1, 16)) * 4;
          2: addr[i] = BASE + 32'(4 * DEPTH) + 32'($urandom_range(15)) * 4;
          3: addr[i] = $urandom;
          default: addr[i] = BASE + 32'($urandom_range(15)) * 4;
        endcase
        we[i]    = ($urandom_range(3) == 0);
        waddr[i] = AW'($urandom_range(15));
        wdata[i] = $urandom;
      end
      cyc();
    end

    idle_all();
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
